// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the instruction/data memory port arbiter.
// Holds the grant FSM state encodings and the owner codes so that the
// hazard unit and the testbench decode the arbiter the same way.
//   arb_state_t : IDLE=0, FETCH=1, DATA=2
//   arb_owner_t : which requester currently owns the memory port
//   owner_of()  : maps a grant state onto its owner
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_t;

  // The owner of the port follows directly from the grant state; IDLE owns
  // nothing, so memory responses seen in IDLE never reach a requester.
  function automatic arb_owner_t owner_of(input arb_state_t s);
    arb_owner_t o;
    o = OWNER_NONE;
    case (s)
      FETCH:   o = OWNER_IF;
      DATA:    o = OWNER_D;
      default: o = OWNER_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_register.sv
// ---------------------------------------------------------------------------
// register_32_variable
// Loadable holding register of width N+1 with asynchronous active-high reset.
// Used for the fetch and load read-data holding registers of the arbiter.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (clears q)
//   load : capture d on the next rising edge
//   d    : data in
//   q    : held data out
// ---------------------------------------------------------------------------
module register_32_variable #(
  parameter int N = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N:0]   d,
  output logic [N:0]   q
);

  // Keep the last captured word until the next load so the consumer can
  // read it at any time after the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (MEM). A three-state grant FSM picks an owner, registers the
// owner's request onto the mem_* bus, waits for mem_ready, captures read
// data into a holding register and pulses the owner's ack for one cycle.
// Data accesses win ties, but after STARVE_MAX consecutive data grants with
// a fetch waiting, the next grant is forced to the fetch side.
// Ports:
//   clk, rst                     clock, async active-high reset
//   if_req/if_addr               fetch request and address
//   if_ack/if_rdata              fetch done pulse, held fetched word
//   d_req/d_we/d_addr/d_wdata/d_be  data request (store when d_we=1)
//   d_ack/d_rdata                data done pulse, held load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered memory request
//   mem_ready/mem_rdata          memory completion and read data
//   stall                        pipeline stall while a request is pending
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic              if_ack,
  output logic [DW-1:0]     if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  input  logic [DW/8-1:0]   d_be,
  output logic              d_ack,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_ready,
  input  logic [DW-1:0]     mem_rdata,
  output logic              stall
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [CW-1:0] starve_cnt;
  logic          grant_if;
  logic          grant_d;
  logic          done;
  logic          if_load;
  logic          d_load;

  // Next-state and grant decisions. Arbitration only happens in an IDLE
  // cycle that is not also an ack cycle, so a requester still holding its
  // request during its own ack is not granted a second time; the request is
  // looked at again in the following IDLE cycle. In FETCH/DATA the FSM just
  // waits for the memory to complete.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!if_ack && !d_ack) begin
          if (if_req && d_req) begin
            if (starve_cnt == STARVE_LIM) begin
              grant_if = 1'b1;
            end else begin
              grant_d = 1'b1;
            end
          end else if (if_req) begin
            grant_if = 1'b1;
          end else if (d_req) begin
            grant_d = 1'b1;
          end
        end
        if (grant_if) begin
          state_next = FETCH;
        end else if (grant_d) begin
          state_next = DATA;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant FSM state register; an async reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory request registers, acks and the starvation counter. On a grant
  // the owner's request is latched and mem_req raised; the bus then stays
  // frozen until the completing edge, which drops mem_req and fires the
  // owner's one-cycle ack. The counter only grows while a fetch is actually
  // waiting behind data grants, and saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_if) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        mem_be     <= '1;
        starve_cnt <= '0;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        if (!if_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end
      if (done) begin
        mem_req <= 1'b0;
        if_ack  <= (owner_of(state) == OWNER_IF);
        d_ack   <= (owner_of(state) == OWNER_D);
      end
    end
  end

  // Read data is captured on the completing edge of a read owned by the
  // matching requester; stores leave the load data register untouched.
  assign if_load = mem_ready && (owner_of(state) == OWNER_IF) && !mem_we;
  assign d_load  = mem_ready && (owner_of(state) == OWNER_D)  && !mem_we;

  register_32_variable #(.N(DW-1)) u_if_rdata (
    .clk  (clk),
    .rst  (rst),
    .load (if_load),
    .d    (mem_rdata),
    .q    (if_rdata)
  );

  register_32_variable #(.N(DW-1)) u_d_rdata (
    .clk  (clk),
    .rst  (rst),
    .load (d_load),
    .d    (mem_rdata),
    .q    (d_rdata)
  );

  // Stall drops in the ack cycle itself so the pipeline advances on the
  // edge that ends the access.
  assign stall = (if_req && !if_ack) || (d_req && !d_ack);

endmodule
